data_mem_responder: RTL and testbench

Responder end of the CPU data-memory interface. Accepts the load/store requests the core issues in EX, performs byte/half/word accesses against an on-chip synchronous RAM plus one memory-mapped LED register, and returns load data one cycle later for capture in the MEM stage. Misaligned and out-of-range accesses are reported through a sticky error flag with the faulting address.

---
 rtl/data_mem_responder_pkg.sv | 13 +
 rtl/data_mem_responder_dmem_bram.sv | 21 ++
 rtl/data_mem_responder.sv | 92 +++++++++
 tb/tb_data_mem_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared size encodings, default address map and load-source type
package data_mem_responder_pkg;
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;
  localparam int UNS_BIT = 3;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;
  localparam logic [31:0] DEF_LED_ADDR = 32'h0000_2000;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_LED} src_e;
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/data_mem_responder_dmem_bram.sv
// dmem_bram: single-port synchronous RAM with byte write enables and a registered read port
module dmem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_q <= mem[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with RAM, LED register, load extraction and sticky error capture
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        memwrite_i,
  input  logic        memread_i,
  input  logic [3:0]  sign_mask_i,
  output logic [31:0] read_data_o,
  output logic [7:0]  led_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [2:0] sz, sz_q, sz_d;
  logic [31:0] off, wdata, bmask, ram_q, word, sh;
  logic ram_hit, led_hit, size_ok, aligned, err, ram_re;
  logic [3:0] be, ram_we;
  logic [31:0] led_q, led_d, err_addr_q, err_addr_d, snap_q, snap_d;
  logic err_q, err_d, uns_q, uns_d;
  logic [1:0] off_q, off_d;
  src_e src_q, src_d;
  always_comb begin
    sz = sign_mask_i[2:0];
    off = addr_i - BASE_ADDR;
    ram_hit = off < 32'(4 * DEPTH_WORDS);
    led_hit = addr_i == LED_ADDR;
    size_ok = sz == SZ_BYTE || sz == SZ_HALF || sz == SZ_WORD;
    aligned = sz == SZ_WORD ? addr_i[1:0] == 2'b00 : sz == SZ_HALF ? !addr_i[0] : 1'b1;
    err = (memread_i | memwrite_i) &
          (!size_ok | !aligned | !(ram_hit | led_hit) | (memread_i & memwrite_i));
    be = sz == SZ_WORD ? 4'hf : sz == SZ_HALF ? (addr_i[1] ? 4'hc : 4'h3) : 4'b0001 << addr_i[1:0];
    wdata = sz == SZ_WORD ? wr_data_i : sz == SZ_HALF ? {2{wr_data_i[15:0]}} : {4{wr_data_i[7:0]}};
    bmask = lane_mask(be);
    ram_we = (memwrite_i & !err & ram_hit & !reset_i) ? be : 4'h0;
    ram_re = memread_i & !err & ram_hit & !reset_i;
    led_d = (memwrite_i & !err & led_hit) ? (led_q & ~bmask) | (wdata & bmask) : led_q;
    err_d = err_q | err;
    err_addr_d = (err & !err_q) ? addr_i : err_addr_q;
    // Load fields (and the LED snapshot) only move on a load, so read data holds otherwise
    src_d = !memread_i ? src_q : err ? SRC_ZERO : ram_hit ? SRC_RAM : SRC_LED;
    off_d = memread_i ? addr_i[1:0] : off_q;
    sz_d = memread_i ? sz : sz_q;
    uns_d = memread_i ? sign_mask_i[UNS_BIT] : uns_q;
    snap_d = memread_i ? led_q : snap_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      led_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
      src_q <= SRC_ZERO;
      off_q <= '0;
      sz_q <= '0;
      uns_q <= 1'b0;
      snap_q <= '0;
    end else begin
      led_q <= led_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
      src_q <= src_d;
      off_q <= off_d;
      sz_q <= sz_d;
      uns_q <= uns_d;
      snap_q <= snap_d;
    end
  end
  dmem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (off[AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (ram_q)
  );
  always_comb begin
    word = src_q == SRC_RAM ? ram_q : src_q == SRC_LED ? snap_q : '0;
    sh = word >> {off_q, 3'b000};
    read_data_o = sz_q == SZ_BYTE ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                  sz_q == SZ_HALF ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  end
  assign led_o = led_q[7:0];
  assign err_o = err_q;
  assign err_addr_o = err_addr_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench with a byte-level reference model of the data-memory responder
module tb_data_mem_responder;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] LED = 32'h0000_2000;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, reset_i = 1'b1;
  logic [31:0] addr_i = '0, wr_data_i = '0;
  logic memwrite_i = 1'b0, memread_i = 1'b0;
  logic [3:0] sign_mask_i = '0;
  logic [31:0] read_data_o, err_addr_o;
  logic [7:0] led_o;
  logic err_o;
  int checks = 0, fails = 0;
  typedef struct packed {logic [31:0] rd; logic [7:0] led; logic err; logic [31:0] ea;} exp_t;
  exp_t q[$];
  logic [7:0] mem_m [int unsigned];
  logic [31:0] led_m = '0, rd_m = '0, ea_m = '0;
  logic err_m = 1'b0;
  data_mem_responder dut (
    .clk_i(clk), .reset_i(reset_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .memwrite_i(memwrite_i), .memread_i(memread_i), .sign_mask_i(sign_mask_i),
    .read_data_o(read_data_o), .led_o(led_o), .err_o(err_o), .err_addr_o(err_addr_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: little-endian byte array; n bytes at address a
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sm);
    int n;
    logic ram, ledh, bad;
    logic [31:0] v;
    n = sm[2:0] == 3'b001 ? 1 : sm[2:0] == 3'b010 ? 2 : sm[2:0] == 3'b100 ? 4 : 0;
    ram = a >= BASE && a < BASE + 4 * DEPTH;
    ledh = a == LED;
    bad = (rd || wr) && (n == 0 || (a % n) != 0 || !(ram || ledh) || (rd && wr));
    if (bad && !err_m) begin
      err_m = 1'b1;
      ea_m = a;
    end
    if (wr && !bad)
      for (int k = 0; k < n; k++)
        if (ram) mem_m[a - BASE + k] = wd[8*k +: 8];
        else led_m[8*k +: 8] = wd[8*k +: 8];
    if (rd) begin
      v = '0;
      if (!bad)
        for (int k = 0; k < n; k++)
          v[8*k +: 8] = ram ? mem_m[a - BASE + k] : led_m[8*k +: 8];
      if (!bad && n < 4 && !sm[3] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd_m = v;
    end
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sm);
    @(negedge clk);
    memread_i = rd;
    memwrite_i = wr;
    addr_i = a;
    wr_data_i = wd;
    sign_mask_i = sm;
    model(rd, wr, a, wd, sm);
    q.push_back('{rd: rd_m, led: led_m[7:0], err: err_m, ea: ea_m});
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("read_data_o", read_data_o, e.rd);
        chk("led_o", {24'h0, led_o}, {24'h0, e.led});
        chk("err_o", {31'h0, err_o}, {31'h0, e.err});
        chk("err_addr_o", err_addr_o, e.ea);
      end
    end
  end
  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin : stim
    logic [31:0] a;
    logic [3:0] sm;
    int op, k;
    logic [31:0] miss_list [6];
    miss_list = '{BASE - 1, BASE - 4, BASE + 4 * DEPTH, 32'h3000, LED + 4, 32'h0};
    #12;
    chk("reset read_data_o", read_data_o, 32'h0);
    chk("reset led_o", {24'h0, led_o}, 32'h0);
    chk("reset err_o", {31'h0, err_o}, 32'h0);
    chk("reset err_addr_o", err_addr_o, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 34; i++)
      drive(1'b0, 1'b1, BASE + 4 * (i < 32 ? i : 990 + i), $urandom, 4'b0100);
    drive(0, 1, 32'h1004, 32'hDEAD_BEEF, 4'b0100);
    drive(1, 0, 32'h1004, 0, 4'b0100);
    drive(0, 1, 32'h1005, 32'h80, 4'b0001);
    drive(1, 0, 32'h1005, 0, 4'b0001);
    drive(1, 0, 32'h1005, 0, 4'b1001);
    drive(1, 0, 32'h1004, 0, 4'b0100);
    drive(0, 1, 32'h1006, 32'h1234, 4'b0010);
    drive(1, 0, 32'h1006, 0, 4'b0010);
    drive(0, 0, 32'h1006, 0, 4'b0010);
    drive(1, 0, 32'h1003, 0, 4'b0010);
    drive(0, 1, 32'h3000, 32'hFFFF_FFFF, 4'b0100);
    drive(1, 0, 32'h1004, 0, 4'b0100);
    drive(0, 1, 32'h2000, 32'hA5, 4'b0001);
    drive(1, 0, 32'h2000, 0, 4'b0100);
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("queue drained before reset", q.size(), 0);
    @(negedge clk);
    memwrite_i = 1'b1;
    addr_i = LED;
    wr_data_i = 32'h5A;
    sign_mask_i = 4'b0001;
    #2 reset_i = 1'b1;
    #1;
    chk("async read_data_o", read_data_o, 32'h0);
    chk("async led_o", {24'h0, led_o}, 32'h0);
    chk("async err_o", {31'h0, err_o}, 32'h0);
    chk("async err_addr_o", err_addr_o, 32'h0);
    @(negedge clk);
    reset_i = 1'b0;
    memwrite_i = 1'b0;
    led_m = '0;
    rd_m = '0;
    err_m = 1'b0;
    ea_m = '0;
    @(posedge clk);
    #2 chk("store during reset dropped", {24'h0, led_o}, 32'h0);
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 9);
      k = $urandom_range(0, 9);
      if (k < 7) begin
        k = $urandom_range(0, 33);
        a = BASE + 4 * (k < 32 ? k : 990 + k) + $urandom_range(0, 3);
      end else if (k == 7) a = LED + ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      else a = miss_list[$urandom_range(0, 5)];
      sm[2:0] = $urandom_range(0, 15) == 0 ? 3'($urandom_range(0, 7)) : 3'b001 << $urandom_range(0, 2);
      sm[3] = 1'($urandom_range(0, 1));
      drive(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8, a, $urandom, sm);
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    chk("final queue drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
